// File: rtl/fpga_run_sequencer_if.sv
// Channel, core and drain-stream signals of the run sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface fpga_run_sequencer_if #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NIn                = 3,
  parameter int unsigned StepWidth          = 16
);
  localparam int unsigned AddrW = $clog2(NIn);

  logic                          start;
  logic                          inValid;
  logic [MemoryElementWidth-1:0] inData;
  logic                          inReady;
  logic [AddrW-1:0]              coreInAddr;
  logic [MemoryElementWidth-1:0] coreInData;
  logic                          coreRun;
  logic                          coreStep;
  logic                          coreOutWrite;
  logic [MemoryElementWidth-1:0] coreOutData;
  logic                          coreFinished;
  logic                          coreSuccess;
  logic                          outValid;
  logic [MemoryElementWidth-1:0] outData;
  logic                          outReady;
  logic                          busy;
  logic                          done;
  logic                          passed;
  logic                          timedOut;
  logic [StepWidth-1:0]          steps;

  modport slave (
    input  start, inValid, inData, coreInAddr, coreOutWrite, coreOutData,
           coreFinished, coreSuccess, outReady,
    output inReady, coreInData, coreRun, coreStep, outValid, outData,
           busy, done, passed, timedOut, steps
  );

  modport master (
    output start, inValid, inData, coreInAddr, coreOutWrite, coreOutData,
           coreFinished, coreSuccess, outReady,
    input  inReady, coreInData, coreRun, coreStep, outValid, outData,
           busy, done, passed, timedOut, steps
  );
endinterface

// File: rtl/fpga_run_sequencer.sv
// Run controller for one interpreter core: loads input words, steps the core
// under a budget, captures its output words circularly and drains them.
module fpga_run_sequencer #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NIn                = 3,
  parameter int unsigned NOut               = 9,
  parameter int unsigned MaxSteps           = 32,
  parameter int unsigned StepWidth          = 16
) (
  input logic                 clock,
  input logic                 reset,
  fpga_run_sequencer_if.slave bus
);
  localparam int unsigned AddrW   = $clog2(NIn);
  localparam int unsigned InDepth = 1 << AddrW;
  localparam int unsigned InCntW  = $clog2(NIn + 1);
  localparam int unsigned WpW     = $clog2(NOut);
  localparam int unsigned OutCntW = $clog2(NOut + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t                        state;
  logic [MemoryElementWidth-1:0] in_buf  [InDepth];
  logic [MemoryElementWidth-1:0] out_buf [NOut];
  logic [InCntW-1:0]             in_count;
  logic [WpW-1:0]                wp;
  logic [OutCntW-1:0]            out_count;
  logic [OutCntW-1:0]            rd_index;
  logic [StepWidth-1:0]          steps_q;
  logic                          passed_q;
  logic                          timed_out_q;
  logic                          in_ready_q;
  logic                          core_run_q;
  logic                          busy_q;
  logic                          done_q;

  logic [StepWidth-1:0]          steps_inc;
  logic                          out_valid;

  assign steps_inc = steps_q + StepWidth'(1);
  assign out_valid = (state == DRAIN) && (rd_index < out_count);

  // Sequencer FSM; status flags are registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      for (int i = 0; i < InDepth; i++) in_buf[i] <= '0;
      for (int i = 0; i < NOut; i++) out_buf[i] <= '0;
      in_count    <= '0;
      wp          <= '0;
      out_count   <= '0;
      rd_index    <= '0;
      steps_q     <= '0;
      passed_q    <= 1'b0;
      timed_out_q <= 1'b0;
      in_ready_q  <= 1'b0;
      core_run_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= LOAD;
            for (int i = 0; i < InDepth; i++) in_buf[i] <= '0;
            in_count    <= '0;
            wp          <= '0;
            out_count   <= '0;
            steps_q     <= '0;
            passed_q    <= 1'b0;
            timed_out_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.inValid) begin
            in_buf[AddrW'(in_count)] <= bus.inData;
            in_count                 <= in_count + InCntW'(1);
            if (in_count == InCntW'(NIn - 1)) begin
              state      <= RUN;
              in_ready_q <= 1'b0;
              core_run_q <= 1'b1;
            end
          end
        end
        RUN: begin
          steps_q <= steps_inc;
          // A write on the final step is kept even though the run ends here.
          if (bus.coreOutWrite) begin
            out_buf[wp] <= bus.coreOutData;
            wp          <= (wp == WpW'(NOut - 1)) ? '0 : wp + WpW'(1);
            if (out_count != OutCntW'(NOut)) out_count <= out_count + OutCntW'(1);
          end
          if (bus.coreFinished || (steps_inc == StepWidth'(MaxSteps))) begin
            state       <= DRAIN;
            core_run_q  <= 1'b0;
            rd_index    <= '0;
            passed_q    <= bus.coreFinished && bus.coreSuccess;
            timed_out_q <= !bus.coreFinished;
          end
        end
        DRAIN: begin
          if (rd_index == out_count) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (bus.outReady) begin
            rd_index <= rd_index + OutCntW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inReady    = in_ready_q;
  assign bus.coreRun    = core_run_q;
  assign bus.coreStep   = core_run_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.passed     = passed_q;
  assign bus.timedOut   = timed_out_q;
  assign bus.steps      = steps_q;
  assign bus.outValid   = out_valid;
  assign bus.outData    = out_valid ? out_buf[WpW'(rd_index)] : '0;
  assign bus.coreInData = ({1'b0, bus.coreInAddr} < (AddrW + 1)'(NIn)) ?
                          in_buf[bus.coreInAddr] : '0;
endmodule

// File: tb/tb_fpga_run_sequencer.sv
// Randomized bench for fpga_run_sequencer against a queue-based run model.
module tb_fpga_run_sequencer;
  localparam int W    = 12;
  localparam int NIN  = 3;
  localparam int NOUT = 9;
  localparam int MAXS = 32;
  localparam int SW   = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fpga_run_sequencer_if #(.MemoryElementWidth(W), .NIn(NIN), .StepWidth(SW)) bus ();

  fpga_run_sequencer #(
    .MemoryElementWidth(W), .NIn(NIN), .NOut(NOUT), .MaxSteps(MAXS), .StepWidth(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks;
  int errors;

  // Core program plan (1-based step index) and input words
  bit           plan_wr  [1:64];
  logic [W-1:0] plan_dat [1:64];
  int           plan_fin;
  bit           plan_succ;
  int           plan_start_at;
  logic [W-1:0] in_words [NIN];

  // Observations and model expectations
  int           pulses, addr_bad, hold_bad, drain_cycles;
  logic [W-1:0] got_q [$];
  logic [W-1:0] exp_q [$];
  int           exp_steps;
  bit           exp_to, exp_ps;
  int           wrap_exp [9] = '{10, 11, 3, 4, 5, 6, 7, 8, 9};

  task automatic clear_plan();
    for (int k = 1; k <= 64; k++) begin plan_wr[k] = 1'b0; plan_dat[k] = '0; end
    plan_fin = 0; plan_succ = 1'b0; plan_start_at = 0;
  endtask

  task automatic rand_plan(input int fin_lo, input int fin_hi);
    clear_plan();
    for (int k = 1; k <= 64; k++) begin
      plan_wr[k]  = 1'($urandom);
      plan_dat[k] = W'($urandom);
    end
    plan_fin  = int'($urandom_range(fin_hi, fin_lo));
    plan_succ = 1'($urandom);
    for (int i = 0; i < NIN; i++) in_words[i] = W'($urandom);
  endtask

  // Run outcome from the plan: budget cut-off, then the last NOut writes by slot.
  task automatic exp_model();
    logic [W-1:0] w [$];
    int n, m;
    exp_to    = !(plan_fin >= 1 && plan_fin <= MAXS);
    exp_steps = exp_to ? MAXS : plan_fin;
    exp_ps    = !exp_to && plan_succ;
    for (int k = 1; k <= exp_steps; k++) if (plan_wr[k]) w.push_back(plan_dat[k]);
    n = w.size();
    m = (n < NOUT) ? n : NOUT;
    exp_q.delete();
    for (int i = 0; i < m; i++) exp_q.push_back(w[i + NOUT * ((n - 1 - i) / NOUT)]);
  endtask

  task automatic do_start();
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
  endtask

  task automatic do_load(input bit gaps);
    int  idx = 0;
    bit  phase = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (idx == NIN) break;
      bus.inData = W'($urandom);
      if (gaps && phase) bus.inValid = 1'b0;
      else begin bus.inValid = 1'b1; bus.inData = in_words[idx]; end
      if (bus.inValid && bus.inReady) idx++;
      phase = !phase;
      @(negedge clock);
    end
    bus.inValid = 1'b0;
  endtask

  task automatic do_run();
    int k = 0;
    int addr;
    logic [W-1:0] want;
    pulses = 0; addr_bad = 0;
    for (int c = 0; c < 200; c++) begin
      if (!bus.coreRun) break;
      k++;
      if (bus.coreStep) pulses++;
      bus.coreOutWrite = (k <= 64) ? plan_wr[k] : 1'b0;
      bus.coreOutData  = (k <= 64) ? plan_dat[k] : '0;
      bus.coreFinished = (k == plan_fin);
      bus.coreSuccess  = (k == plan_fin) ? plan_succ : 1'($urandom);
      bus.start        = (k == plan_start_at);
      bus.inValid      = 1'($urandom);
      bus.inData       = W'($urandom);
      addr             = int'($urandom_range(3, 0));
      bus.coreInAddr   = 2'(addr);
      #1;
      want = (addr < NIN) ? in_words[addr] : '0;
      if (bus.coreInData !== want) addr_bad++;
      @(negedge clock);
    end
    bus.coreOutWrite = 1'b0; bus.coreFinished = 1'b0; bus.coreSuccess = 1'b0;
    bus.start = 1'b0; bus.inValid = 1'b0;
  endtask

  task automatic do_drain(input bit rand_ready);
    bit           pend = 1'b0;
    logic [W-1:0] pend_dat = '0;
    bit           r;
    got_q.delete(); hold_bad = 0; drain_cycles = 0;
    for (int c = 0; c < 500; c++) begin
      if (bus.done) break;
      drain_cycles++;
      r = rand_ready ? 1'($urandom) : 1'b1;
      bus.outReady = r;
      #1;
      if (pend && (!bus.outValid || bus.outData !== pend_dat)) hold_bad++;
      if (bus.outValid && r) begin got_q.push_back(bus.outData); pend = 1'b0; end
      else if (bus.outValid) begin pend = 1'b1; pend_dat = bus.outData; end
      else pend = 1'b0;
      @(negedge clock);
    end
    bus.outReady = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if ({bus.inReady, bus.coreRun, bus.coreStep, bus.outValid, bus.busy, bus.done, bus.passed, bus.timedOut} !== 8'b0) begin errors++; $display("FAIL reset_flags got %b exp 0", {bus.inReady, bus.coreRun, bus.coreStep, bus.outValid, bus.busy, bus.done, bus.passed, bus.timedOut}); end
    checks++; if (bus.steps !== SW'(0)) begin errors++; $display("FAIL reset_steps got %0d exp 0", bus.steps); end
    checks++; if (bus.outData !== W'(0)) begin errors++; $display("FAIL reset_outData got %0d exp 0", bus.outData); end
    checks++; if (bus.coreInData !== W'(0)) begin errors++; $display("FAIL reset_coreInData got %0d exp 0", bus.coreInData); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy %b done %b exp 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_nominal();
    int seq [9] = '{1, 2, 3, 3, 33, 2, 22, 1, 11};
    clear_plan();
    in_words[0] = W'(33); in_words[1] = W'(22); in_words[2] = W'(11);
    for (int k = 1; k <= 9; k++) begin plan_wr[k] = 1'b1; plan_dat[k] = W'(seq[k-1]); end
    plan_fin = 20; plan_succ = 1'b1;
    do_start();
    checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL nom_start_latency inReady %b exp 1", bus.inReady); end
    do_load(1'b0);
    do_run();
    checks++; if (bus.coreStep !== 1'b0) begin errors++; $display("FAIL nom_step_after_finish got %b exp 0", bus.coreStep); end
    checks++; if (pulses !== 20) begin errors++; $display("FAIL nom_pulses got %0d exp 20", pulses); end
    checks++; if (addr_bad !== 0) begin errors++; $display("FAIL nom_coreInData bad reads %0d exp 0", addr_bad); end
    do_drain(1'b0);
    checks++; if (got_q.size() !== 9) begin errors++; $display("FAIL nom_drain_count got %0d exp 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== W'(seq[i])) begin errors++; $display("FAIL nom_word%0d got %0d exp %0d", i, got_q[i], seq[i]); end
    end
    checks++; if (drain_cycles !== 10) begin errors++; $display("FAIL nom_throughput cycles %0d exp 10", drain_cycles); end
    checks++; if ({bus.done, bus.passed, bus.timedOut, bus.busy} !== 4'b1100) begin errors++; $display("FAIL nom_status done/passed/timedOut/busy got %b exp 1100", {bus.done, bus.passed, bus.timedOut, bus.busy}); end
    checks++; if (bus.steps !== SW'(20)) begin errors++; $display("FAIL nom_steps got %0d exp 20", bus.steps); end
  endtask

  task automatic test_timeout();
    rand_plan(0, 0);
    exp_model();
    do_start(); do_load(1'b0); do_run();
    checks++; if (pulses !== MAXS) begin errors++; $display("FAIL to_pulses got %0d exp %0d", pulses, MAXS); end
    checks++; if (bus.busy !== 1'b1 || bus.outValid !== (exp_q.size() != 0)) begin errors++; $display("FAIL to_drain_entry busy %b outValid %b", bus.busy, bus.outValid); end
    do_drain(1'b0);
    checks++; if (got_q !== exp_q) begin errors++; $display("FAIL to_words got %p exp %p", got_q, exp_q); end
    checks++; if ({bus.done, bus.timedOut, bus.passed} !== 3'b110) begin errors++; $display("FAIL to_status done/timedOut/passed got %b exp 110", {bus.done, bus.timedOut, bus.passed}); end
    checks++; if (bus.steps !== SW'(MAXS)) begin errors++; $display("FAIL to_steps got %0d exp %0d", bus.steps, MAXS); end
  endtask

  task automatic test_wrap();
    clear_plan();
    for (int i = 0; i < NIN; i++) in_words[i] = W'($urandom);
    for (int k = 1; k <= 11; k++) begin plan_wr[k] = 1'b1; plan_dat[k] = W'(k); end
    plan_fin = 15; plan_succ = 1'b0;
    do_start(); do_load(1'b0); do_run(); do_drain(1'b0);
    checks++; if (got_q.size() !== 9) begin errors++; $display("FAIL wrap_count got %0d exp 9", got_q.size()); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== W'(wrap_exp[i])) begin errors++; $display("FAIL wrap_word%0d got %0d exp %0d", i, got_q[i], wrap_exp[i]); end
    end
    checks++; if ({bus.done, bus.passed, bus.timedOut} !== 3'b100) begin errors++; $display("FAIL wrap_status got %b exp 100", {bus.done, bus.passed, bus.timedOut}); end
  endtask

  task automatic test_backpressure();
    for (int it = 0; it < 3; it++) begin
      rand_plan(4, 40);
      exp_model();
      do_start(); do_load(1'b1); do_run();
      checks++; if (addr_bad !== 0) begin errors++; $display("FAIL bp%0d_input_order bad reads %0d exp 0", it, addr_bad); end
      do_drain(1'b1);
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp%0d_hold violations %0d exp 0", it, hold_bad); end
      checks++; if (got_q !== exp_q) begin errors++; $display("FAIL bp%0d_words got %p exp %p", it, got_q, exp_q); end
      checks++; if (bus.steps !== SW'(exp_steps) || bus.timedOut !== exp_to || bus.passed !== exp_ps) begin errors++; $display("FAIL bp%0d_status steps %0d to %b ps %b exp %0d %b %b", it, bus.steps, bus.timedOut, bus.passed, exp_steps, exp_to, exp_ps); end
    end
  endtask

  task automatic test_simultaneous();
    for (int it = 0; it < 2; it++) begin
      rand_plan(MAXS, MAXS);
      plan_wr[MAXS] = 1'b1;
      plan_succ = (it == 0);
      exp_model();
      do_start(); do_load(1'b0); do_run(); do_drain(1'b1);
      checks++; if (got_q !== exp_q) begin errors++; $display("FAIL sim%0d_words got %p exp %p", it, got_q, exp_q); end
      checks++; if (bus.timedOut !== 1'b0 || bus.passed !== (it == 0)) begin errors++; $display("FAIL sim%0d_status to %b ps %b exp 0 %b", it, bus.timedOut, bus.passed, it == 0); end
      checks++; if (bus.steps !== SW'(MAXS)) begin errors++; $display("FAIL sim%0d_steps got %0d exp %0d", it, bus.steps, MAXS); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      rand_plan(1, 45);
      exp_model();
      do_start(); do_load(1'($urandom)); do_run();
      checks++; if (pulses !== exp_steps) begin errors++; $display("FAIL rnd%0d_pulses got %0d exp %0d", it, pulses, exp_steps); end
      do_drain(1'($urandom));
      checks++; if (got_q !== exp_q) begin errors++; $display("FAIL rnd%0d_words got %p exp %p", it, got_q, exp_q); end
      checks++; if (bus.done !== 1'b1 || bus.timedOut !== exp_to || bus.passed !== exp_ps) begin errors++; $display("FAIL rnd%0d_status done %b to %b ps %b exp 1 %b %b", it, bus.done, bus.timedOut, bus.passed, exp_to, exp_ps); end
    end
  endtask

  task automatic test_control();
    // start pulsed mid-run must not disturb it
    rand_plan(12, 12);
    plan_succ = 1'b1; plan_start_at = 5;
    exp_model();
    do_start(); do_load(1'b0); do_run();
    checks++; if (pulses !== 12) begin errors++; $display("FAIL ctl_start_in_run pulses %0d exp 12", pulses); end
    do_drain(1'b0);
    checks++; if (got_q !== exp_q || bus.passed !== 1'b1 || bus.steps !== SW'(12)) begin errors++; $display("FAIL ctl_start_in_run result ps %b steps %0d exp 1 12", bus.passed, bus.steps); end
    // restart from DONE clears the previous result
    do_start();
    checks++; if ({bus.done, bus.passed, bus.timedOut, bus.inReady} !== 4'b0001 || bus.steps !== SW'(0)) begin errors++; $display("FAIL ctl_restart done/ps/to/inReady %b steps %0d exp 0001 0", {bus.done, bus.passed, bus.timedOut, bus.inReady}, bus.steps); end
    do_load(1'b0);
    bus.coreInAddr = 2'd0;
    repeat (3) @(negedge clock);
    checks++; if (bus.coreRun !== 1'b1 || bus.steps === SW'(0)) begin errors++; $display("FAIL ctl_pre_abort coreRun %b steps %0d exp 1 nonzero", bus.coreRun, bus.steps); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({bus.inReady, bus.coreRun, bus.coreStep, bus.outValid, bus.busy, bus.done, bus.passed, bus.timedOut} !== 8'b0 || bus.steps !== SW'(0) || bus.coreInData !== W'(0)) begin errors++; $display("FAIL ctl_async_abort flags %b steps %0d coreInData %0d exp 0 0 0", {bus.inReady, bus.coreRun, bus.coreStep, bus.outValid, bus.busy, bus.done, bus.passed, bus.timedOut}, bus.steps, bus.coreInData); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    checks++; if ({bus.busy, bus.done, bus.inReady, bus.coreRun} !== 4'b0) begin errors++; $display("FAIL ctl_idle_after_abort got %b exp 0000", {bus.busy, bus.done, bus.inReady, bus.coreRun}); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.inValid = 1'b0; bus.inData = '0; bus.coreInAddr = '0;
    bus.coreOutWrite = 1'b0; bus.coreOutData = '0; bus.coreFinished = 1'b0;
    bus.coreSuccess = 1'b0; bus.outReady = 1'b0;
    clear_plan();
    for (int i = 0; i < NIN; i++) in_words[i] = '0;
    test_reset();
    test_nominal();
    test_timeout();
    test_wrap();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_control();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpga_run_sequencer.md
# fpga_run_sequencer

Run controller for one interpreter core instance. It buffers the program's input channel words, sequences the core through a bounded number of instruction steps, and collects the words the core writes to its output channel. When the core finishes or exhausts its step budget, it drains those words over a valid/ready stream and reports pass, fail or timeout. It replaces free-running self-clocked test harnesses with a single-clock, resettable wrapper usable on the FPGA.

## Interface
- MemoryElementWidth, 12, width of every channel word
- NIn, 3, input channel depth in words
- NOut, 9, output channel depth in words (circular)
- MaxSteps, 32, step budget per run; must be at least 1
- StepWidth, 16, width of the step counter

- clock  in  1  sole clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE
- inValid  in  1  input word offered during LOAD
- inData  in  MemoryElementWidth  input word
- inReady  out  1  high only in LOAD
- coreInAddr  in  $clog2(NIn)  core read address into the input buffer
- coreInData  out  MemoryElementWidth  combinational read of the input buffer at coreInAddr; 0 if coreInAddr >= NIn
- coreRun  out  1  high while in RUN
- coreStep  out  1  one instruction enable per cycle while in RUN
- coreOutWrite  in  1  core writes coreOutData this cycle
- coreOutData  in  MemoryElementWidth  core output word
- coreFinished  in  1  core has completed its program
- coreSuccess  in  1  core self-check result; sampled with coreFinished
- outValid  out  1  drained word available
- outData  out  MemoryElementWidth  drained word
- outReady  in  1  consumer accepts outData
- busy  out  1  high in LOAD, RUN and DRAIN
- done  out  1  high in DONE
- passed  out  1  in DONE: core finished with success and no timeout
- timedOut  out  1  in DONE: budget exhausted without coreFinished
- steps  out  StepWidth  number of coreStep cycles issued in the current or last run

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE. Reset enters IDLE.
- **IDLE/DONE**
  - start moves to LOAD.
  - On that edge: input buffer, inCount, output write pointer wp, outCount, steps, passed and timedOut are cleared.
- **LOAD**
  - inReady=1; each inValid&&inReady writes inBuf[inCount] and increments inCount.
  - When the accepted word makes inCount==NIn, move to RUN on the same edge.
- **RUN**
  - coreRun=coreStep=1; steps increments every cycle.
  - coreOutWrite writes outBuf[wp]; wp=(wp+1) mod NOut; outCount saturates at NOut. Older words are overwritten on wrap.
  - coreFinished: latch passed=coreSuccess and move to DRAIN.
  - Otherwise, if the incremented steps equals MaxSteps: set timedOut=1, passed=0, move to DRAIN.
  - coreFinished on the budget cycle counts as finished, not timeout.
  - A coreOutWrite in the same cycle as coreFinished or timeout is still stored.
- **DRAIN**
  - rdIndex starts at 0. outValid=(rdIndex<outCount). outData=outBuf[rdIndex], in physical buffer order 0..outCount-1.
  - rdIndex increments on outValid&&outReady.
  - When rdIndex==outCount, move to DONE; with outCount==0 this happens after one cycle.
- coreOutWrite outside RUN is ignored. inValid outside LOAD is ignored. start in LOAD, RUN or DRAIN is ignored.

## Timing
- Reset values:
  - outputs inReady, coreRun, coreStep, outValid, busy, done, passed, timedOut = 0
  - outData = 0, steps = 0
  - all buffers = 0, so coreInData = 0
- start to inReady high: 1 cycle.
- Minimum LOAD duration: NIn cycles. coreRun rises the cycle after the last input word is accepted.
- Step pulses per run: equal to the final steps value; never more than MaxSteps.
- Leaving RUN: coreStep is low the cycle after coreFinished is sampled.
- Drain: outData is held stable while outValid&&!outReady. Throughput is 1 word/cycle with outReady held high.
- done, passed and timedOut hold until the next accepted start or reset.
- Asynchronous reset during any state aborts the run immediately. All outputs take their reset values without waiting for a clock edge.

## Test plan
- **Nominal run:** load 33,22,11. Core model emits 1,2,3,3,33,2,22,1,11, then asserts coreFinished with coreSuccess=1 on its 20th step. Required: drain returns exactly those 9 words in order, then done=1, passed=1, timedOut=0, steps=20.
- **Timeout:** core never finishes, MaxSteps=32. Required: exactly 32 coreStep pulses, then DRAIN, then done=1, timedOut=1, passed=0, steps=32.
- **Wrap:** core writes 1..11 with NOut=9. Required: outCount=9 and drain yields 10,11,3,4,5,6,7,8,9.
- **Backpressure and input gaps:** inValid toggles every other cycle and outReady is random. Required: inputs are stored in order, and each outData is held unchanged until accepted with no duplicates or drops.
- **Simultaneous events:** coreFinished and coreOutWrite occur together on step MaxSteps. Required: word stored, passed follows coreSuccess, timedOut=0.
- **Control:**
  - start pulsed during RUN: ignored.
  - reset asserted mid-RUN: all outputs 0 asynchronously, then IDLE.
  - start in DONE: restarts with steps, passed and timedOut cleared.
